// File: rtl/enigma_pkg.sv
// Shared Enigma types: letter index/one-hot encodings, plugboard pair entry and
// programming FSM states.
package enigma_pkg;

    localparam int unsigned LETTERS = 26;

    typedef logic [4:0]         letter_idx_t;
    typedef logic [LETTERS-1:0] letter_oh_t;

    typedef struct packed {
        logic        valid;
        letter_idx_t a;
        letter_idx_t b;
    } pair_entry_t;

    typedef enum logic {
        P_IDLE  = 1'b0,
        P_FIRST = 1'b1
    } prog_state_t;

endpackage

// File: rtl/plugboard_ctrl_letter_encoder.sv
// One-hot to 5-bit letter index; o_legal is low for a zero or multi-hot input.
module letter_encoder
    import enigma_pkg::*;
(
    input  letter_oh_t  i_onehot,
    output letter_idx_t o_idx,
    output logic        o_legal
);

    always_comb begin
        o_idx = '0;
        for (int unsigned i = 0; i < LETTERS; i++) begin
            if (i_onehot[i]) o_idx = letter_idx_t'(i);
        end
        o_legal = (i_onehot != '0) && ((i_onehot & (i_onehot - letter_oh_t'(1))) == '0);
    end

endmodule

// File: rtl/plugboard_ctrl.sv
// Enigma plugboard: programmable symmetric letter-pair table plus registered encode path.
// Optional macro PLUGBOARD_UNPLUG_EN: re-entering a plugged first letter removes its pair.
module plugboard_ctrl
    import enigma_pkg::*;
#(
    parameter int unsigned MAX_PAIRS = 10
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [25:0] letter_in,
    input  logic        letter_valid,
    input  logic        prog_mode,
    input  logic        clear_pairs,
    output logic [25:0] letter_out,
    output logic        out_valid,
    output logic [3:0]  pair_count,
    output logic        half_pair,
    output logic        prog_err,
    output logic        bad_letter
);

    localparam int unsigned IW = (MAX_PAIRS > 1) ? $clog2(MAX_PAIRS) : 1;

    pair_entry_t  r_table [MAX_PAIRS];
    prog_state_t  r_state;
    prog_state_t  w_state_next;
    letter_idx_t  r_first;
    logic [3:0]   r_pair_count;
    letter_oh_t   r_letter_out;
    logic         r_out_valid;
    logic         r_prog_err;
    logic         r_bad_letter;

    letter_idx_t  w_idx;
    logic         w_legal;
    logic         w_strobe;
    logic         w_hit;
    letter_idx_t  w_partner;
    letter_oh_t   w_partner_oh;
    logic [IW-1:0] w_hit_entry;
    logic [IW-1:0] w_free_entry;
    logic         w_full;
    logic         w_commit;
    logic         w_remove;
    logic         w_err;
    logic         w_latch;
    logic         w_half_pair;

    letter_encoder u_encoder (
        .i_onehot (letter_in),
        .o_idx    (w_idx),
        .o_legal  (w_legal)
    );

    // clear_pairs swallows a coincident strobe entirely, in either mode
    assign w_strobe     = letter_valid && !clear_pairs;
    assign w_full       = (r_pair_count == 4'(MAX_PAIRS));
    assign w_partner_oh = letter_oh_t'(1) << w_partner;

    always_comb begin
        logic found;
        w_hit        = 1'b0;
        w_partner    = w_idx;
        w_hit_entry  = '0;
        w_free_entry = '0;
        found        = 1'b0;
        for (int unsigned i = 0; i < MAX_PAIRS; i++) begin
            if (r_table[i].valid) begin
                if (r_table[i].a == w_idx) begin
                    w_hit       = 1'b1;
                    w_partner   = r_table[i].b;
                    w_hit_entry = IW'(i);
                end else if (r_table[i].b == w_idx) begin
                    w_hit       = 1'b1;
                    w_partner   = r_table[i].a;
                    w_hit_entry = IW'(i);
                end
            end else if (!found) begin
                found        = 1'b1;
                w_free_entry = IW'(i);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) r_state <= P_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_commit     = 1'b0;
        w_remove     = 1'b0;
        w_err        = 1'b0;
        w_latch      = 1'b0;
        if (clear_pairs || !prog_mode) begin
            w_state_next = P_IDLE;
        end else if (w_strobe && w_legal) begin
            w_state_next = P_IDLE;
            case (r_state)
                P_IDLE: begin
                    if (w_hit) begin
`ifdef PLUGBOARD_UNPLUG_EN
                        w_remove = 1'b1;
`else
                        w_err    = 1'b1;
`endif
                    end else if (w_full) begin
                        w_err = 1'b1;
                    end else begin
                        w_latch      = 1'b1;
                        w_state_next = P_FIRST;
                    end
                end
                P_FIRST: begin
                    if (w_hit || (w_idx == r_first)) w_err = 1'b1;
                    else                             w_commit = 1'b1;
                end
                default: w_state_next = P_IDLE;
            endcase
        end
    end

    always_comb begin
        w_half_pair = (r_state == P_FIRST);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < MAX_PAIRS; i++) r_table[i] <= '0;
            r_first      <= '0;
            r_pair_count <= '0;
            r_letter_out <= '0;
            r_out_valid  <= 1'b0;
            r_prog_err   <= 1'b0;
            r_bad_letter <= 1'b0;
        end else begin
            r_out_valid  <= w_strobe && w_legal && !prog_mode;
            r_bad_letter <= w_strobe && !w_legal;
            r_prog_err   <= w_err;
            if (w_strobe && w_legal && !prog_mode) r_letter_out <= w_partner_oh;
            if (w_latch) r_first <= w_idx;
            if (clear_pairs) begin
                for (int unsigned i = 0; i < MAX_PAIRS; i++) r_table[i].valid <= 1'b0;
                r_pair_count <= '0;
            end else if (w_commit) begin
                r_table[w_free_entry] <= '{valid: 1'b1, a: r_first, b: w_idx};
                r_pair_count          <= r_pair_count + 4'd1;
            end else if (w_remove) begin
                r_table[w_hit_entry].valid <= 1'b0;
                r_pair_count               <= r_pair_count - 4'd1;
            end
        end
    end

    assign letter_out = r_letter_out;
    assign out_valid  = r_out_valid;
    assign pair_count = r_pair_count;
    assign half_pair  = w_half_pair;
    assign prog_err   = r_prog_err;
    assign bad_letter = r_bad_letter;

endmodule

// File: tb/tb_plugboard_ctrl.sv
// Scoreboard bench for plugboard_ctrl: stimulus queues expected output pulses,
// a negedge monitor pops and compares them; status outputs are checked inline.
module tb_plugboard_ctrl;

    localparam logic [2:0] K_OUT = 3'b100;
    localparam logic [2:0] K_BAD = 3'b010;
    localparam logic [2:0] K_ERR = 3'b001;

    typedef struct packed {
        logic [2:0]  kind;
        logic [25:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [25:0] letter_in = '0;
    logic        letter_valid = 1'b0;
    logic        prog_mode = 1'b0;
    logic        clear_pairs = 1'b0;
    logic [25:0] letter_out;
    logic        out_valid;
    logic [3:0]  pair_count;
    logic        half_pair;
    logic        prog_err;
    logic        bad_letter;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    plugboard_ctrl #(.MAX_PAIRS(10)) dut (
        .CLOCK_50     (clk),
        .reset        (reset),
        .letter_in    (letter_in),
        .letter_valid (letter_valid),
        .prog_mode    (prog_mode),
        .clear_pairs  (clear_pairs),
        .letter_out   (letter_out),
        .out_valid    (out_valid),
        .pair_count   (pair_count),
        .half_pair    (half_pair),
        .prog_err     (prog_err),
        .bad_letter   (bad_letter)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: every output pulse must match the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (out_valid || bad_letter || prog_err)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got flags %b letter %0h expected no pulse",
                             {out_valid, bad_letter, prog_err}, letter_out);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind == K_OUT)
                        check("encode_out", {3'b0, out_valid, bad_letter, prog_err, letter_out},
                              {3'b0, e.kind, e.data});
                    else
                        check("pulse_kind", {29'b0, out_valid, bad_letter, prog_err},
                              {29'b0, e.kind});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [25:0] l);
        letter_in    = l;
        letter_valid = 1'b1;
        cyc(1);
        letter_valid = 1'b0;
        letter_in    = '0;
    endtask

    task automatic encode(input logic [25:0] l, input logic [25:0] exp_l);
        prog_mode = 1'b0;
        exp_q.push_back('{kind: K_OUT, data: exp_l});
        pulse(l);
    endtask

    task automatic prog(input logic [25:0] l);
        prog_mode = 1'b1;
        pulse(l);
    endtask

    task automatic prog_reject(input logic [25:0] l);
        prog_mode = 1'b1;
        exp_q.push_back('{kind: K_ERR, data: '0});
        pulse(l);
    endtask

    task automatic do_clear();
        clear_pairs = 1'b1;
        cyc(1);
        clear_pairs = 1'b0;
    endtask

    initial begin
        logic [25:0] va;
        logic [25:0] vb;

        cyc(3);
        check("rst_letter_out", {6'b0, letter_out}, 32'h0);
        check("rst_flags", {27'b0, out_valid, bad_letter, prog_err, half_pair, 1'b0}, 32'h0);
        check("rst_pair_count", {28'b0, pair_count}, 32'h0);
        reset = 1'b0;
        cyc(1);

        encode(26'h1, 26'h1);
        cyc(2);

        prog(26'h1);
        check("half_after_first", {31'b0, half_pair}, 32'h1);
        prog(26'h2);
        check("count_one_pair", {28'b0, pair_count}, 32'h1);
        check("half_after_commit", {31'b0, half_pair}, 32'h0);
        encode(26'h1, 26'h2);
        encode(26'h2, 26'h1);
        encode(26'h4, 26'h4);
        cyc(2);

        do_clear();
        check("count_after_clear", {28'b0, pair_count}, 32'h0);
        prog(26'h1);
        prog_reject(26'h1);
        check("same_letter_count", {28'b0, pair_count}, 32'h0);
        check("same_letter_half", {31'b0, half_pair}, 32'h0);

        for (int k = 0; k < 10; k++) begin
            va = 26'h1 << (2 * k);
            vb = 26'h1 << (2 * k + 1);
            prog(va);
            prog(vb);
        end
        check("count_full", {28'b0, pair_count}, 32'd10);
        prog_reject(26'h1 << 20);
        check("full_count_held", {28'b0, pair_count}, 32'd10);
        check("full_half", {31'b0, half_pair}, 32'h0);
        encode(26'h1 << 19, 26'h1 << 18);
        cyc(2);

        do_clear();
        prog(26'h1);
        prog(26'h2);
        prog(26'h4);
        prog_reject(26'h1);
        check("second_plugged_count", {28'b0, pair_count}, 32'h1);

        prog_mode = 1'b0;
        exp_q.push_back('{kind: K_BAD, data: '0});
        pulse(26'h3);
        cyc(2);

        prog(26'h4);
        exp_q.push_back('{kind: K_BAD, data: '0});
        pulse(26'h0);
        check("bad_keeps_first", {31'b0, half_pair}, 32'h1);
        prog(26'h8);
        check("commit_after_bad", {28'b0, pair_count}, 32'h2);
        encode(26'h8, 26'h4);
        cyc(2);

        do_clear();
        prog(26'h4);
        prog(26'h8);
        prog(26'h1);
        clear_pairs  = 1'b1;
        letter_in    = 26'h2;
        letter_valid = 1'b1;
        cyc(1);
        clear_pairs  = 1'b0;
        letter_valid = 1'b0;
        letter_in    = '0;
        check("clear_with_strobe_count", {28'b0, pair_count}, 32'h0);
        check("clear_with_strobe_half", {31'b0, half_pair}, 32'h0);
        cyc(2);

        prog(26'h1);
        prog_mode = 1'b0;
        cyc(1);
        check("mode_drop_half", {31'b0, half_pair}, 32'h0);
        prog(26'h2);
        prog(26'h4);
        encode(26'h2, 26'h4);
        encode(26'h1, 26'h1);
        cyc(2);

        do_clear();
        prog(26'h1);
        prog(26'h2);
`ifdef PLUGBOARD_UNPLUG_EN
        prog(26'h2);
        check("unplug_count", {28'b0, pair_count}, 32'h0);
        check("unplug_half", {31'b0, half_pair}, 32'h0);
        encode(26'h1, 26'h1);
`else
        prog_reject(26'h2);
        check("replug_count", {28'b0, pair_count}, 32'h1);
        check("replug_half", {31'b0, half_pair}, 32'h0);
        encode(26'h1, 26'h2);
`endif
        cyc(2);

        prog(26'h10);
        #2 reset = 1'b1;
        cyc(1);
        check("rst_mid_pair_half", {31'b0, half_pair}, 32'h0);
        check("rst_mid_pair_count", {28'b0, pair_count}, 32'h0);
        reset = 1'b0;
        prog_mode    = 1'b0;
        letter_in    = 26'h1;
        letter_valid = 1'b1;
        #2 reset = 1'b1;
        cyc(1);
        letter_valid = 1'b0;
        letter_in    = '0;
        check("rst_mid_encode_valid", {31'b0, out_valid}, 32'h0);
        reset = 1'b0;
        cyc(3);

        check("queue_drained", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
